id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the register file read ports.
- Captures both source operands, the immediate, PC and control for one instruction per cycle.
- Bypasses same-cycle writeback data: the register file writes on posedge and reads combinationally, so a write and a read of the same register in one cycle would otherwise capture stale data.
- Detects load-use hazards, inserts bubbles, honours downstream hold and branch flush, and counts inserted bubbles.

Parameters:
- XLEN, 64, datapath width.
- CTRL_W, 8, width of opaque ALU/branch control bundle.
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_rd_addr  in  5  destination index
- id_ctrl  in  CTRL_W  control bundle
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes rd
- wb_wen  in  1  writeback write enable (same signal driving register file write)
- wb_rd_addr  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  branch/jump redirect, kill decode instruction
- ex_hold  in  1  execute stage cannot accept; hold outputs
- id_stall  out  1  hold PC and IF/ID register this cycle
- ex_valid, ex_mem_read, ex_reg_write  out  1  registered flags
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN  registered data
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5  registered indices
- ex_ctrl  out  CTRL_W  registered control
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst=1 at posedge):
  - All registered outputs and bubble_cnt clear to 0.
  - Reset mid-operation discards any in-flight instruction.
- Operand select, combinational, per source n:
  - If id_rsn_addr==0, the operand is 0.
  - Else if wb_wen && wb_rd_addr==id_rsn_addr, the operand is wb_data.
  - Else the operand is id_rsn_data.
  - A write to x0 is never bypassed.
- Hazard (combinational): hazard = id_valid && ex_valid && ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr).
- id_stall = (hazard | ex_hold) & ~flush.
- Per-posedge priority:
  - rst: as above.
  - flush: ex_valid, ex_reg_write, ex_mem_read <= 0; other fields hold. Flush overrides ex_hold.
  - ex_hold: all outputs hold; bubble_cnt holds.
  - hazard: bubble. ex_valid, ex_reg_write, ex_mem_read <= 0; other fields hold; bubble_cnt += 1, saturating at all-ones.
  - Normal: capture all id_* fields and the selected operands. ex_valid <= id_valid. ex_reg_write and ex_mem_read are gated by id_valid.
- Latency: 1 cycle from decode to ex_* outputs.
- Throughput: 1 instruction per cycle absent hazard/hold.
- A load-use pair costs exactly one bubble. The cycle after the bubble, ex_mem_read=0, so hazard deasserts and the held decode instruction advances.
- ex_rs*_addr are registered unchanged for the downstream forwarding unit.

Decomposition:
- Shared package riscv_pkg:
  - XLEN
  - REG_ADDR_W=5
  - X0 index constant
  - CTRL_W and ctrl field offsets
- Sub-module operand_bypass: combinational x0/writeback select, instantiated twice (rs1, rs2).

Test Plan:
1. rst held 2 cycles, then id_valid=1, pc=0x100, rs1=x10 data 0xFFF, rs2=x6 data 0x8 -> next cycle ex_valid=1, ex_pc=0x100, ex_rs1_data=0xFFF, ex_rs2_data=0x8; before that, all outputs 0.
2. Same-cycle bypass: id rs1=x20, id_rs1_data=0x456701023D2, wb_wen=1, wb_rd_addr=20, wb_data=0x1234 -> ex_rs1_data=0x1234. Repeat with wb_rd_addr=0 and id_rs1_addr=0 -> ex_rs1_data=0.
3. Load-use: load to x7 in EX (ex_mem_read=1), then an ID instruction reading x7 -> id_stall=1 for 1 cycle, ex_valid=0 for 1 cycle, bubble_cnt=1, then the dependent instruction appears with ex_valid=1. Load to x0 followed by a reader of x0 -> no stall.
4. ex_hold=1 for 3 cycles with a valid instruction in EX -> ex_* outputs constant, id_stall=1, bubble_cnt unchanged.
5. flush=1 together with hazard=1 and ex_hold=1 -> id_stall=0, next ex_valid=0, ex_reg_write=0, bubble_cnt unchanged.
6. Preload bubble_cnt to 0xFFFE via repeated hazards (or a forced value), then two more hazards -> saturates at 0xFFFF. Assert rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the decode/execute boundary.
package riscv_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 8;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // Field layout of the opaque control bundle; the stage passes it through untouched.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_BR_LSB     = 4;
    localparam int CTRL_BR_W       = 3;
    localparam int CTRL_USE_IMM    = 7;

    // What the pipeline register does on the next edge when not in reset.
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_FLUSH   = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_BUBBLE  = 2'd3
    } stage_act_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/writeback/control inputs and execute-side outputs of the ID/EX register.
interface id_ex_stage_if import riscv_pkg::*; #(
    parameter int CNT_W = 16
) ();
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_imm;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [CTRL_W-1:0]     id_ctrl;
    logic                  id_mem_read;
    logic                  id_reg_write;
    logic                  wb_wen;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  flush;
    logic                  ex_hold;

    logic                  id_stall;
    logic                  ex_valid;
    logic                  ex_mem_read;
    logic                  ex_reg_write;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_imm;
    logic [XLEN-1:0]       ex_rs1_data;
    logic [XLEN-1:0]       ex_rs2_data;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rs1_data,
               id_rs2_data, id_rd_addr, id_ctrl, id_mem_read, id_reg_write,
               wb_wen, wb_rd_addr, wb_data, flush, ex_hold,
        input  id_stall, ex_valid, ex_mem_read, ex_reg_write, ex_pc, ex_imm,
               ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rs1_data,
               id_rs2_data, id_rd_addr, id_ctrl, id_mem_read, id_reg_write,
               wb_wen, wb_rd_addr, wb_data, flush, ex_hold,
        output id_stall, ex_valid, ex_mem_read, ex_reg_write, ex_pc, ex_imm,
               ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/operand_bypass.sv
// Source operand select: x0 reads zero, a same-cycle writeback wins over the
// register file read (the file writes on the edge that captures this operand).
module operand_bypass import riscv_pkg::*; (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       operand
);
    // Priority select; rs_addr==x0 also blocks a bogus bypass of a write to x0.
    always_comb begin
        operand = rs_data;
        if (rs_addr == X0) begin
            operand = '0;
        end else if (wb_wen && (wb_rd_addr == rs_addr)) begin
            operand = wb_data;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// downstream hold, branch flush and a saturating bubble counter.
module id_ex_stage import riscv_pkg::*; #(
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    logic                  hazard;
    stage_act_e            act;
    logic [XLEN-1:0]       rs1_op;
    logic [XLEN-1:0]       rs2_op;

    logic                  ex_valid;
    logic                  ex_mem_read;
    logic                  ex_reg_write;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_imm;
    logic [XLEN-1:0]       ex_rs1_data;
    logic [XLEN-1:0]       ex_rs2_data;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [CNT_W-1:0]      bubble_cnt;

    operand_bypass u_rs1_bypass (
        .rs_addr   (bus.id_rs1_addr),
        .rs_data   (bus.id_rs1_data),
        .wb_wen    (bus.wb_wen),
        .wb_rd_addr(bus.wb_rd_addr),
        .wb_data   (bus.wb_data),
        .operand   (rs1_op)
    );

    operand_bypass u_rs2_bypass (
        .rs_addr   (bus.id_rs2_addr),
        .rs_data   (bus.id_rs2_data),
        .wb_wen    (bus.wb_wen),
        .wb_rd_addr(bus.wb_rd_addr),
        .wb_data   (bus.wb_data),
        .operand   (rs2_op)
    );

    // Load-use detection and next-edge action; flush outranks hold, hold outranks the bubble.
    always_comb begin
        hazard = bus.id_valid && ex_valid && ex_mem_read && (ex_rd_addr != X0) &&
                 ((ex_rd_addr == bus.id_rs1_addr) || (ex_rd_addr == bus.id_rs2_addr));
        act = ACT_CAPTURE;
        if (bus.flush) begin
            act = ACT_FLUSH;
        end else if (bus.ex_hold) begin
            act = ACT_HOLD;
        end else if (hazard) begin
            act = ACT_BUBBLE;
        end
    end

    assign bus.id_stall = (hazard || bus.ex_hold) && !bus.flush;

    // Pipeline register update; killed slots keep their payload, only the flags drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd_addr   <= '0;
            ex_ctrl      <= '0;
            bubble_cnt   <= '0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    ex_valid     <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_reg_write <= 1'b0;
                end
                ACT_BUBBLE: begin
                    ex_valid     <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_reg_write <= 1'b0;
                    if (bubble_cnt != {CNT_W{1'b1}}) begin
                        bubble_cnt <= bubble_cnt + 1'b1;
                    end
                end
                ACT_CAPTURE: begin
                    ex_valid     <= bus.id_valid;
                    ex_mem_read  <= bus.id_valid && bus.id_mem_read;
                    ex_reg_write <= bus.id_valid && bus.id_reg_write;
                    ex_pc        <= bus.id_pc;
                    ex_imm       <= bus.id_imm;
                    ex_rs1_data  <= rs1_op;
                    ex_rs2_data  <= rs2_op;
                    ex_rs1_addr  <= bus.id_rs1_addr;
                    ex_rs2_addr  <= bus.id_rs2_addr;
                    ex_rd_addr   <= bus.id_rd_addr;
                    ex_ctrl      <= bus.id_ctrl;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ex_valid     = ex_valid;
    assign bus.ex_mem_read  = ex_mem_read;
    assign bus.ex_reg_write = ex_reg_write;
    assign bus.ex_pc        = ex_pc;
    assign bus.ex_imm       = ex_imm;
    assign bus.ex_rs1_data  = ex_rs1_data;
    assign bus.ex_rs2_data  = ex_rs2_data;
    assign bus.ex_rs1_addr  = ex_rs1_addr;
    assign bus.ex_rs2_addr  = ex_rs2_addr;
    assign bus.ex_rd_addr   = ex_rd_addr;
    assign bus.ex_ctrl      = ex_ctrl;
    assign bus.bubble_cnt   = bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against an instruction-level model.
module tb_id_ex_stage;
    localparam int TB_CNT_W = 8;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.CNT_W(TB_CNT_W)) bus ();

    id_ex_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference state: the instruction currently sitting in EX.
    logic        m_valid, m_mr, m_rw;
    logic [63:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]  m_a1, m_a2, m_rd;
    logic [7:0]  m_ctrl;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_operand(input logic [4:0] a, input logic [63:0] d);
        if (a == 5'd0) return 64'd0;
        if (bus.wb_wen && bus.wb_rd_addr == a) return bus.wb_data;
        return d;
    endfunction

    function automatic logic ref_hazard();
        return bus.id_valid && m_valid && m_mr && m_rd != 5'd0 &&
               (m_rd == bus.id_rs1_addr || m_rd == bus.id_rs2_addr);
    endfunction

    function automatic logic ref_stall();
        return (ref_hazard() || bus.ex_hold) && !bus.flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_mr = 0; m_rw = 0;
        m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0;
        m_a1 = 0; m_a2 = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    task automatic model_next();
        logic hz;
        hz = ref_hazard();
        if (rst) begin
            model_reset();
        end else if (bus.flush || (!bus.ex_hold && hz)) begin
            m_valid = 0; m_mr = 0; m_rw = 0;
            if (!bus.flush && m_cnt < CNT_MAX) m_cnt++;
        end else if (!bus.ex_hold) begin
            m_d1    = ref_operand(bus.id_rs1_addr, bus.id_rs1_data);
            m_d2    = ref_operand(bus.id_rs2_addr, bus.id_rs2_data);
            m_valid = bus.id_valid;
            m_mr    = bus.id_valid && bus.id_mem_read;
            m_rw    = bus.id_valid && bus.id_reg_write;
            m_pc    = bus.id_pc;
            m_imm   = bus.id_imm;
            m_a1    = bus.id_rs1_addr;
            m_a2    = bus.id_rs2_addr;
            m_rd    = bus.id_rd_addr;
            m_ctrl  = bus.id_ctrl;
        end
    endtask

    task automatic check_all();
        check("ex_valid",     bus.ex_valid,     m_valid);
        check("ex_mem_read",  bus.ex_mem_read,  m_mr);
        check("ex_reg_write", bus.ex_reg_write, m_rw);
        check("ex_pc",        bus.ex_pc,        m_pc);
        check("ex_imm",       bus.ex_imm,       m_imm);
        check("ex_rs1_data",  bus.ex_rs1_data,  m_d1);
        check("ex_rs2_data",  bus.ex_rs2_data,  m_d2);
        check("ex_rs1_addr",  bus.ex_rs1_addr,  m_a1);
        check("ex_rs2_addr",  bus.ex_rs2_addr,  m_a2);
        check("ex_rd_addr",   bus.ex_rd_addr,   m_rd);
        check("ex_ctrl",      bus.ex_ctrl,      m_ctrl);
        check("bubble_cnt",   bus.bubble_cnt,   64'(m_cnt));
    endtask

    // One clock: check stall with settled inputs, advance model, check registered outputs.
    task automatic step();
        #1;
        check("id_stall", bus.id_stall, ref_stall());
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_imm = 0;
        bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
        bus.id_rd_addr = 0; bus.id_ctrl = 0; bus.id_mem_read = 0; bus.id_reg_write = 0;
        bus.wb_wen = 0; bus.wb_rd_addr = 0; bus.wb_data = 0; bus.flush = 0; bus.ex_hold = 0;
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [4:0] rs1, input logic [63:0] d1,
                             input logic [4:0] rs2, input logic [63:0] d2, input logic [4:0] rd,
                             input logic ld);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_imm = pc + 64'h10;
        bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
        bus.id_rs2_addr = rs2; bus.id_rs2_data = d2;
        bus.id_rd_addr = rd; bus.id_ctrl = pc[7:0]; bus.id_mem_read = ld; bus.id_reg_write = 1;
    endtask

    initial begin
        model_reset();
        set_idle();
        rst = 1;

        // Reset held two cycles: everything reads zero.
        @(posedge clk);
        #1;
        step();
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ex_pc", bus.ex_pc, 0);

        // First instruction, one-cycle latency.
        rst = 0;
        set_instr(64'h100, 5'd10, 64'hFFF, 5'd6, 64'h8, 5'd1, 0);
        #1;
        check("pre_ex_valid", bus.ex_valid, 0);
        step();
        check("t1_ex_valid", bus.ex_valid, 1);
        check("t1_ex_pc", bus.ex_pc, 64'h100);
        check("t1_rs1", bus.ex_rs1_data, 64'hFFF);
        check("t1_rs2", bus.ex_rs2_data, 64'h8);

        // Same-cycle writeback bypass, then x0 never bypassed.
        set_instr(64'h104, 5'd20, 64'h456701023D2, 5'd6, 64'h8, 5'd2, 0);
        bus.wb_wen = 1; bus.wb_rd_addr = 5'd20; bus.wb_data = 64'h1234;
        step();
        check("byp_rs1", bus.ex_rs1_data, 64'h1234);
        set_instr(64'h108, 5'd0, 64'h456701023D2, 5'd6, 64'h8, 5'd2, 0);
        bus.wb_rd_addr = 5'd0;
        step();
        check("x0_rs1", bus.ex_rs1_data, 0);
        bus.wb_wen = 0;

        // Load-use on x7: exactly one bubble.
        set_instr(64'h10C, 5'd1, 64'h11, 5'd2, 64'h22, 5'd7, 1);
        step();
        check("ld_mem_read", bus.ex_mem_read, 1);
        set_instr(64'h110, 5'd7, 64'h77, 5'd3, 64'h33, 5'd8, 0);
        #1;
        check("lu_stall", bus.id_stall, 1);
        step();
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_bubble_cnt", bus.bubble_cnt, 1);
        check("lu_stall_release", bus.id_stall, 0);
        step();
        check("lu_dep_valid", bus.ex_valid, 1);
        check("lu_dep_pc", bus.ex_pc, 64'h110);

        // Load into x0 never stalls a reader of x0.
        set_instr(64'h114, 5'd1, 64'h1, 5'd2, 64'h2, 5'd0, 1);
        step();
        set_instr(64'h118, 5'd0, 64'h5, 5'd0, 64'h6, 5'd9, 0);
        #1;
        check("x0_load_stall", bus.id_stall, 0);
        step();

        // Downstream hold for three cycles.
        set_instr(64'h200, 5'd3, 64'h3, 5'd4, 64'h4, 5'd5, 0);
        step();
        bus.ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(64'h300 + 64'(i), 5'd1, 64'h9, 5'd2, 64'h9, 5'd6, 0);
            step();
            check("hold_pc", bus.ex_pc, 64'h200);
            check("hold_stall", bus.id_stall, 1);
            check("hold_cnt", bus.bubble_cnt, 1);
        end

        // Flush together with hazard and hold.
        bus.ex_hold = 0;
        set_instr(64'h400, 5'd1, 64'h1, 5'd2, 64'h2, 5'd7, 1);
        step();
        set_instr(64'h404, 5'd7, 64'h7, 5'd2, 64'h2, 5'd8, 0);
        bus.ex_hold = 1; bus.flush = 1;
        #1;
        check("flush_stall", bus.id_stall, 0);
        step();
        check("flush_valid", bus.ex_valid, 0);
        check("flush_reg_write", bus.ex_reg_write, 0);
        check("flush_cnt", bus.bubble_cnt, 1);
        check("flush_pc_held", bus.ex_pc, 64'h400);
        bus.ex_hold = 0; bus.flush = 0;

        // Randomized traffic with narrow register range to provoke hazards and bypasses.
        for (int i = 0; i < 400; i++) begin
            bus.id_valid     = ($urandom_range(0, 9) < 8);
            bus.id_pc        = {$urandom(), $urandom()};
            bus.id_imm       = {$urandom(), $urandom()};
            bus.id_rs1_addr  = 5'($urandom_range(0, 7));
            bus.id_rs2_addr  = 5'($urandom_range(0, 7));
            bus.id_rs1_data  = {$urandom(), $urandom()};
            bus.id_rs2_data  = {$urandom(), $urandom()};
            bus.id_rd_addr   = 5'($urandom_range(0, 7));
            bus.id_ctrl      = 8'($urandom());
            bus.id_mem_read  = ($urandom_range(0, 9) < 4);
            bus.id_reg_write = 1'($urandom());
            bus.wb_wen       = 1'($urandom());
            bus.wb_rd_addr   = 5'($urandom_range(0, 7));
            bus.wb_data      = {$urandom(), $urandom()};
            bus.flush        = ($urandom_range(0, 19) == 0);
            bus.ex_hold      = ($urandom_range(0, 9) == 0);
            rst              = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 0;
        set_idle();

        // Saturation: a self-dependent load repeats a hazard every other cycle.
        set_instr(64'h500, 5'd7, 64'h7, 5'd3, 64'h3, 5'd7, 1);
        for (int i = 0; i < 2000 && m_cnt < CNT_MAX - 1; i++) step();
        check("sat_preload", bus.bubble_cnt, 64'(CNT_MAX - 1));
        for (int i = 0; i < 6; i++) step();
        check("sat_cnt", bus.bubble_cnt, 64'(CNT_MAX));

        // Reset mid-stream with a valid instruction in flight.
        set_instr(64'h600, 5'd1, 64'h1, 5'd2, 64'h2, 5'd3, 0);
        step();
        check("pre_rst_valid", bus.ex_valid, 1);
        rst = 1;
        step();
        check("mid_rst_valid", bus.ex_valid, 0);
        check("mid_rst_pc", bus.ex_pc, 0);
        check("mid_rst_cnt", bus.bubble_cnt, 0);
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
